// File: rtl/tt_um_mac_core.sv
// tt_um_mac_core: TinyTapeout tile holding a 4x4-bit multiply-accumulate unit with a
// 16-bit wrapping accumulator, a sticky overflow flag and a byte-selectable output.
// Ports: clk; rst_n (synchronous, active-high despite the harness name); ena (tile
//   enable, 0 holds state); ui_in = {B, A}; uio_in = {3'bx, smode, bsel[1:0], clr, en};
//   uo_out = byte chosen by bsel; uio_out = {sign, zero, ovf, 5'b0}; uio_oe = 8'hE0.
module tt_um_mac_core #(
  parameter int ACC_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0]       op_a;
  logic [3:0]       op_b;
  logic             en;
  logic             clr;
  logic [1:0]       bsel;
  logic             smode;
  logic [2:0]       unused_uio;

  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic [7:0]        uprod;
  logic signed [7:0] sprod;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W:0]    sum;
  logic              add_ovf;
  logic              sign;
  logic              zero;
  logic [7:0]        sel_byte;

  assign op_a       = ui_in[3:0];
  assign op_b       = ui_in[7:4];
  assign en         = uio_in[0];
  assign clr        = uio_in[1];
  assign bsel       = uio_in[3:2];
  assign smode      = uio_in[4];
  assign unused_uio = uio_in[7:5];

  // Both 4x4 products fit in 8 bits (0..225 unsigned, -56..64 signed), so an
  // 8-bit multiply followed by extension to the accumulator width is exact.
  assign uprod = {4'b0000, op_a} * {4'b0000, op_b};
  assign sprod = $signed({{4{op_a[3]}}, op_a}) * $signed({{4{op_b[3]}}, op_b});
  assign prod  = smode ? {{(ACC_W-8){sprod[7]}}, sprod}
                       : {{(ACC_W-8){1'b0}}, uprod};

  // One adder serves both modes; only the overflow interpretation differs.
  assign sum     = {1'b0, acc} + {1'b0, prod};
  assign add_ovf = smode ? ((acc[ACC_W-1] == prod[ACC_W-1]) &&
                            (sum[ACC_W-1] != acc[ACC_W-1]))
                         : sum[ACC_W];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        acc <= en ? prod : '0;
        ovf <= 1'b0;
      end else if (en) begin
        acc <= sum[ACC_W-1:0];
        if (add_ovf) ovf <= 1'b1;
      end
    end
  end

  assign sign = acc[ACC_W-1];
  assign zero = (acc == '0);

  always_comb begin
    sel_byte = 8'h00;
    case (bsel)
      2'd0: sel_byte = acc[7:0];
      2'd1: sel_byte = acc[15:8];
      2'd2: sel_byte = prod[7:0];
      2'd3: sel_byte = {ovf, zero, sign, 5'b00000};
      default: sel_byte = 8'h00;
    endcase
  end

  // Outputs are forced to their cleared values while reset is held so the pins
  // are defined even before the first reset edge has cleared the registers.
  assign uo_out  = rst_n ? 8'h00 : sel_byte;
  assign uio_out = rst_n ? 8'h40 : {sign, zero, ovf, 5'b00000};
  assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_mac_core.sv
module tb_tt_um_mac_core;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_mac_core #(.ACC_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: accumulator as a plain integer 0..65535.
  int m_acc = 0;
  bit m_ovf = 1'b0;

  // Monitor: every cycle the DUT presents a fresh output set just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (uo_out !== e.uo || uio_out !== e.uio || uio_oe !== 8'hE0) begin
          n_bad++;
          $display("FAIL %s: got uo=%h uio=%h oe=%h, expected uo=%h uio=%h oe=e0",
                   e.name, uo_out, uio_out, uio_oe, e.uo, e.uio);
        end
      end
    end
  end

  function automatic int sx4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // Drive one cycle of inputs and push what the pins must show after the edge.
  task automatic step(input bit rst, input bit en_t, input int a, input int b,
                      input bit en, input bit clr, input int bsel, input bit smode,
                      input string name);
    int   p;
    int   p16;
    int   sacc;
    int   s;
    exp_t e;
    @(negedge clk);
    rst_n  = rst;
    ena    = en_t;
    ui_in  = 8'((b << 4) | a);
    uio_in = {3'($urandom_range(0, 7)), smode, 2'(bsel), clr, en};

    p   = smode ? sx4(a) * sx4(b) : a * b;
    p16 = (p + 65536) % 65536;
    if (rst) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end else if (en_t) begin
      if (clr) begin
        m_acc = en ? p16 : 0;
        m_ovf = 1'b0;
      end else if (en) begin
        if (smode) begin
          sacc = (m_acc >= 32768) ? m_acc - 65536 : m_acc;
          s    = sacc + p;
          if (s > 32767 || s < -32768) m_ovf = 1'b1;
        end else if (m_acc + p16 > 65535) begin
          m_ovf = 1'b1;
        end
        m_acc = (m_acc + p16) % 65536;
      end
    end

    e.name = name;
    if (rst) begin
      e.uo  = 8'h00;
      e.uio = 8'h40;
    end else begin
      e.uio = {m_acc >= 32768, m_acc == 0, m_ovf, 5'b00000};
      case (bsel)
        0:       e.uo = 8'(m_acc % 256);
        1:       e.uo = 8'(m_acc / 256);
        2:       e.uo = 8'(p16 % 256);
        default: e.uo = {m_ovf, m_acc == 0, m_acc >= 32768, 5'b00000};
      endcase
    end
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // 1. Reset held two cycles, then idle.
    step(1, 1, 3, 5, 1, 0, 0, 0, "reset_0");
    step(1, 1, 3, 5, 1, 0, 2, 0, "reset_1");
    step(0, 1, 0, 0, 0, 0, 0, 0, "post_reset");

    // 2. Unsigned MAC 3*5 three times -> 0x2D.
    for (int i = 0; i < 3; i++) step(0, 1, 3, 5, 1, 0, 0, 0, "umac_acc");
    step(0, 1, 3, 5, 0, 0, 0, 0, "umac_lo");
    step(0, 1, 3, 5, 0, 0, 1, 0, "umac_hi");
    step(0, 1, 3, 5, 0, 0, 3, 0, "umac_flags");
    step(0, 1, 3, 5, 0, 0, 2, 0, "umac_prod");

    // 3. Signed -2*7 after clear -> 0xFFF2.
    step(0, 1, 0, 0, 0, 1, 0, 1, "smac_clr");
    step(0, 1, 14, 7, 1, 0, 0, 1, "smac_lo");
    step(0, 1, 14, 7, 0, 0, 1, 1, "smac_hi");
    step(0, 1, 14, 7, 0, 0, 2, 1, "smac_prod");

    // 4. 292 x 225 unsigned wraps to 0x00A4 with sticky ovf, then clr alone.
    step(0, 1, 0, 0, 0, 1, 0, 0, "wrap_clr");
    for (int i = 0; i < 292; i++)
      step(0, 1, 15, 15, 1, 0, $urandom_range(0, 3), 0, "wrap_acc");
    step(0, 1, 15, 15, 0, 0, 0, 0, "wrap_lo");
    step(0, 1, 15, 15, 0, 0, 3, 0, "wrap_flags");
    step(0, 1, 15, 15, 0, 1, 3, 0, "wrap_clear");
    step(0, 1, 15, 15, 0, 0, 0, 0, "wrap_clear_lo");

    // 5. clr+en reloads with the product; ena=0 freezes state.
    step(0, 1, 4, 4, 1, 1, 0, 0, "load_16");
    step(0, 1, 2, 3, 1, 1, 0, 0, "clr_en_6");
    step(0, 1, 2, 3, 0, 0, 3, 0, "clr_en_flags");
    for (int i = 0; i < 5; i++)
      step(0, 0, 7, 9, 1, i[0], i % 4, 0, "ena_hold");

    // 6. Reset mid-run, then accumulation resumes.
    for (int i = 0; i < 4; i++) step(0, 1, 9, 13, 1, 0, 0, 0, "pre_rst");
    step(1, 1, 9, 13, 1, 0, 0, 0, "mid_rst");
    step(0, 1, 9, 13, 1, 0, 0, 0, "resume");

    // Randomized mix of all controls, including signed overflow and mode mixing.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
           $urandom_range(0, 15), $urandom_range(0, 15),
           ($urandom_range(0, 5) != 0), ($urandom_range(0, 29) == 0),
           $urandom_range(0, 3), $urandom_range(0, 1), "random");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses never observed, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
